// File: rtl/amp3_pkg.sv
// -----------------------------------------------------------------------------
// amp3_pkg
// Types and constants shared by the AMP3 sample feeder and its FIFO.
//   feeder_state_e   : playback FSM states (IDLE, PRIME, RUN)
//   DEFAULT_DATASIZE : default sample width per channel
//   level_width()    : width of a fill counter that can hold 0..depth
// -----------------------------------------------------------------------------
package amp3_pkg;

    localparam int DEFAULT_DATASIZE = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } feeder_state_e;

    // A counter holding 0..depth (inclusive) needs one bit more than a pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/amp3_sample_fifo.sv
// -----------------------------------------------------------------------------
// amp3_sample_fifo
// Synchronous first-word-fall-through FIFO holding stereo frames.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and frame; ignored while full
//   pop           : read request; ignored while empty
//   rdata         : head of the FIFO (valid whenever empty = 0)
//   level         : number of stored frames, 0..DEPTH
//   full, empty   : derived from level
// -----------------------------------------------------------------------------
module amp3_sample_fifo
    import amp3_pkg::*;
#(
    parameter int WIDTH = 2 * DEFAULT_DATASIZE,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers wrap modulo DEPTH naturally since DEPTH is a power of two.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; a location is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/amp3_sample_feeder.sv
// -----------------------------------------------------------------------------
// amp3_sample_feeder
// Upstream stage of the AMP3 I2S transmitter: buffers stereo frames, primes
// the FIFO before playback, advances one frame per transmitter frame (rising
// edge of RightNLeft) and mutes with a sticky underrun flag when starved.
// Optional macro AMP3_FEEDER_VOLUME_EN adds a 3-bit vol port that
// arithmetic-right-shifts popped samples.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   s_valid/s_ready           : upstream frame handshake
//   s_dataL, s_dataR          : upstream left/right samples
//   play                      : playback request
//   RightNLeft                : transmitter channel flag (BCLK domain)
//   dataL, dataR              : words presented to the transmitter
//   enable                    : transmitter enable (high in RUN)
//   level                     : FIFO fill in frames
//   underrun                  : sticky starvation flag
//   vol (optional)            : attenuation shift, sampled at each pop
// -----------------------------------------------------------------------------
module amp3_sample_feeder
    import amp3_pkg::*;
#(
    parameter int DATASIZE    = DEFAULT_DATASIZE,
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATASIZE-1:0]           s_dataL,
    input  logic [DATASIZE-1:0]           s_dataR,
    input  logic                          play,
    input  logic                          RightNLeft,
    output logic [DATASIZE-1:0]           dataL,
    output logic [DATASIZE-1:0]           dataR,
    output logic                          enable,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          underrun
`ifdef AMP3_FEEDER_VOLUME_EN
    ,
    input  logic [2:0]                    vol
`endif
);

    localparam int LVL_W = level_width(DEPTH);

    feeder_state_e           state_q, state_d;
    logic [2:0]              sync_q, sync_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [DATASIZE-1:0]     data_l_q, data_l_d;
    logic [DATASIZE-1:0]     data_r_q, data_r_d;
    logic                    underrun_q, underrun_d;
    logic                    pop;
    logic                    fifo_full, fifo_empty;
    logic [2*DATASIZE-1:0]   fifo_rdata;
    logic [DATASIZE-1:0]     head_l, head_r, load_l, load_r;

    amp3_sample_fifo #(
        .WIDTH (2 * DATASIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (pop),
        .wdata ({s_dataL, s_dataR}),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_l = fifo_rdata[2*DATASIZE-1:DATASIZE];
    assign head_r = fifo_rdata[DATASIZE-1:0];

`ifdef AMP3_FEEDER_VOLUME_EN
    assign load_l = $unsigned($signed(head_l) >>> vol);
    assign load_r = $unsigned($signed(head_r) >>> vol);
`else
    assign load_l = head_l;
    assign load_r = head_r;
`endif

    assign s_ready  = !fifo_full;
    assign enable   = (state_q == RUN);
    assign dataL    = data_l_q;
    assign dataR    = data_r_q;
    assign underrun = underrun_q;

    always_comb begin
        // Two synchronizer stages, a third stage for edge detect, then a
        // registered pulse: the pop lands 4 clk after the RightNLeft rise.
        sync_d       = {sync_q[1:0], RightNLeft};
        frame_tick_d = sync_q[1] && !sync_q[2];

        state_d    = state_q;
        data_l_d   = data_l_q;
        data_r_d   = data_r_q;
        underrun_d = underrun_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (play) begin
                    state_d    = PRIME;
                    underrun_d = 1'b0;
                end
            end
            PRIME: begin
                if (!play) begin
                    state_d = IDLE;
                end else if (level >= LVL_W'(PRIME_LEVEL)) begin
                    // Load the first frame on entry so the very first
                    // transmitted frame is already valid.
                    state_d  = RUN;
                    pop      = 1'b1;
                    data_l_d = load_l;
                    data_r_d = load_r;
                end
            end
            RUN: begin
                if (!play) begin
                    state_d = IDLE;
                end else if (frame_tick_q) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        data_l_d = load_l;
                        data_r_d = load_r;
                    end else begin
                        data_l_d   = '0;
                        data_r_d   = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            frame_tick_q <= 1'b0;
            data_l_q     <= '0;
            data_r_q     <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            frame_tick_q <= frame_tick_d;
            data_l_q     <= data_l_d;
            data_r_q     <= data_r_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_amp3_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_amp3_sample_feeder
// Directed bench for amp3_sample_feeder. A queue-based model derived from the
// feeder's behavioural rules is stepped on every clock and compared against
// the DUT on each falling edge; literal checks at key points pin the model.
// -----------------------------------------------------------------------------
module tb_amp3_sample_feeder;

    localparam int DATASIZE    = 12;
    localparam int DEPTH       = 8;
    localparam int PRIME_LEVEL = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                s_valid;
    logic                s_ready;
    logic [DATASIZE-1:0] s_dataL, s_dataR;
    logic                play;
    logic                RightNLeft;
    logic [DATASIZE-1:0] dataL, dataR;
    logic                enable;
    logic [3:0]          level;
    logic                underrun;
    logic [2:0]          vol;

    int n_tests = 0;
    int n_fail  = 0;

    amp3_sample_feeder #(
        .DATASIZE    (DATASIZE),
        .DEPTH       (DEPTH),
        .PRIME_LEVEL (PRIME_LEVEL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_dataL    (s_dataL),
        .s_dataR    (s_dataR),
        .play       (play),
        .RightNLeft (RightNLeft),
        .dataL      (dataL),
        .dataR      (dataR),
        .enable     (enable),
        .level      (level),
        .underrun   (underrun)
`ifdef AMP3_FEEDER_VOLUME_EN
        ,
        .vol        (vol)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    // mode: 0 = stopped, 1 = waiting for the FIFO to prime, 2 = playing.
    logic [2*DATASIZE-1:0] mq[$];
    int                    due[$];
    int                    cyc = 0;
    int                    mode;
    int                    pre_size;
    bit                    tick, rnl_prev, take_push;
    logic [DATASIZE-1:0]   m_l, m_r, raw_l, raw_r;
    bit                    m_und;
    logic [2*DATASIZE-1:0] f;

    task automatic model_take();
        f     = mq.pop_front();
        raw_l = f[2*DATASIZE-1:DATASIZE];
        raw_r = f[DATASIZE-1:0];
`ifdef AMP3_FEEDER_VOLUME_EN
        m_l = $unsigned($signed(raw_l) >>> vol);
        m_r = $unsigned($signed(raw_r) >>> vol);
`else
        m_l = raw_l;
        m_r = raw_r;
`endif
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            due.delete();
            mode     = 0;
            m_l      = '0;
            m_r      = '0;
            m_und    = 0;
            rnl_prev = 0;
        end else begin
            // A RightNLeft rise sampled at this edge advances the frame three edges later.
            tick = 0;
            if (due.size() > 0 && due[0] == cyc) begin
                tick = 1;
                void'(due.pop_front());
            end
            if (RightNLeft && !rnl_prev) due.push_back(cyc + 3);
            rnl_prev  = RightNLeft;
            pre_size  = mq.size();
            take_push = s_valid && (pre_size != DEPTH);
            case (mode)
                0: if (play) begin mode = 1; m_und = 0; end
                1: if (!play) mode = 0;
                   else if (pre_size >= PRIME_LEVEL) begin mode = 2; model_take(); end
                default: if (!play) mode = 0;
                   else if (tick) begin
                       if (pre_size > 0) model_take();
                       else begin m_l = '0; m_r = '0; m_und = 1; end
                   end
            endcase
            if (take_push) mq.push_back({s_dataL, s_dataR});
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("s_ready",  32'(s_ready),  32'(mq.size() != DEPTH));
            check("level",    32'(level),    32'(mq.size()));
            check("enable",   32'(enable),   32'(mode == 2));
            check("dataL",    32'(dataL),    32'(m_l));
            check("dataR",    32'(dataR),    32'(m_r));
            check("underrun", 32'(underrun), 32'(m_und));
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [DATASIZE-1:0] l, input logic [DATASIZE-1:0] r);
        s_valid = 1'b1;
        s_dataL = l;
        s_dataR = r;
        step();
        s_valid = 1'b0;
    endtask

    // One transmitter frame: RightNLeft high for 4 clk then low for 4 clk.
    // Optionally offers a push on exactly the edge where the frame advances.
    task automatic frame(input bit with_push, input logic [DATASIZE-1:0] l,
                         input logic [DATASIZE-1:0] r);
        RightNLeft = 1'b1;
        repeat (3) step();
        if (with_push) begin
            s_valid = 1'b1;
            s_dataL = l;
            s_dataR = r;
        end
        step();
        s_valid    = 1'b0;
        RightNLeft = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_dataL = '0; s_dataR = '0;
        play = 1'b0; RightNLeft = 1'b0; vol = 3'd0;
        #1;
        repeat (2) step();
        rst = 1'b0;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_level",   32'(level),   32'd0);
        check("rst_enable",  32'(enable),  32'd0);
        check("rst_dataL",   32'(dataL),   32'd0);
        check("rst_under",   32'(underrun), 32'd0);

        // Priming: three frames are not enough to start.
        play = 1'b1;
        push_frame(12'h123, 12'h456);
        push_frame(12'h111, 12'h222);
        push_frame(12'h333, 12'h444);
        step();
        check("prime3_enable", 32'(enable), 32'd0);
        check("prime3_level",  32'(level),  32'd3);
        push_frame(12'h555, 12'h666);
        check("prime4_enable_pre", 32'(enable), 32'd0);
        step();
        check("run_enable", 32'(enable), 32'd1);
        check("run_dataL",  32'(dataL),  32'h123);
        check("run_dataR",  32'(dataR),  32'h456);
        check("run_level",  32'(level),  32'd3);

        // Streaming six queued frames.
        push_frame(12'h777, 12'h888);
        push_frame(12'h999, 12'hAAA);
        push_frame(12'hBBB, 12'hCCC);
        check("six_level", 32'(level), 32'd6);
        frame(1'b0, '0, '0);
        check("tick1_dataL", 32'(dataL), 32'h111);
        check("tick1_level", 32'(level), 32'd5);
        repeat (5) frame(1'b0, '0, '0);
        check("tick6_dataR", 32'(dataR), 32'hCCC);
        check("tick6_level", 32'(level), 32'd0);

        // Underrun: one more frame with an empty FIFO mutes.
        frame(1'b0, '0, '0);
        check("ur_dataL",  32'(dataL),    32'd0);
        check("ur_dataR",  32'(dataR),    32'd0);
        check("ur_flag",   32'(underrun), 32'd1);
        check("ur_enable", 32'(enable),   32'd1);
        play = 1'b0;
        step();
        check("stop_enable", 32'(enable), 32'd0);
        check("stop_under",  32'(underrun), 32'd1);
        play = 1'b1;
        step();
        check("replay_under", 32'(underrun), 32'd0);
        play = 1'b0;
        step();

        // Full: fill eight frames while stopped, ninth push is refused.
        for (int i = 0; i < DEPTH; i++)
            push_frame(12'(12'h100 + i), 12'(12'h200 + i));
        check("full_level",   32'(level),   32'd8);
        check("full_s_ready", 32'(s_ready), 32'd0);
        push_frame(12'hFFF, 12'hFFF);
        check("full9_level", 32'(level), 32'd8);
        play = 1'b1;
        step();
        step();
        check("fill_run_dataL", 32'(dataL), 32'h100);
        check("fill_run_level", 32'(level), 32'd7);
        push_frame(12'h0AB, 12'h0CD);
        check("refill_level", 32'(level), 32'd8);
        frame(1'b1, 12'hEEE, 12'hEEE);
        check("blocked_level", 32'(level), 32'd7);
        check("blocked_dataL", 32'(dataL), 32'h101);
        frame(1'b0, '0, '0);
        frame(1'b0, '0, '0);
        check("lvl5", 32'(level), 32'd5);
        frame(1'b1, 12'h0DE, 12'h0F0);
        check("simul_level", 32'(level), 32'd5);
        check("simul_dataR", 32'(dataR), 32'h204);

`ifdef AMP3_FEEDER_VOLUME_EN
        // Volume: shift by 2 at the pop on entry to playback.
        rst = 1'b1;
        play = 1'b0;
        step();
        rst = 1'b0;
        play = 1'b1;
        vol = 3'd2;
        push_frame(12'h800, 12'h100);
        for (int i = 0; i < 3; i++) push_frame(12'h010, 12'h020);
        step();
        check("vol_dataL", 32'(dataL), 32'hE00);
        check("vol_dataR", 32'(dataR), 32'h040);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
